// File: rtl/seq_alu8.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu8
//  Description : Sequential 8-bit ALU coprocessor. Adds, subtracts, performs
//                a signed radix-2 Booth multiply and an unsigned 16/8
//                non-restoring divide. A single 9-bit adder/subtractor is
//                shared by every operation. Operands arrive serially on a
//                16-bit bus, and the result leaves on a registered 16-bit
//                bus with a finish/overflow handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [15:0] inbus,
    output logic [15:0] outbus,
    output logic        finish,
    output logic        of_flag
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_WAIT   = 4'd1;
    localparam logic [3:0] c_ST_LDM    = 4'd2;
    localparam logic [3:0] c_ST_ADDSUB = 4'd3;
    localparam logic [3:0] c_ST_ASOUT  = 4'd4;
    localparam logic [3:0] c_ST_MUL    = 4'd5;
    localparam logic [3:0] c_ST_MULOUT = 4'd6;
    localparam logic [3:0] c_ST_DIV    = 4'd7;
    localparam logic [3:0] c_ST_DIVCOR = 4'd8;
    localparam logic [3:0] c_ST_DIVOUT = 4'd9;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_q;
    logic [7:0] r_m;
    logic       r_q1;
    logic       r_sign;   // divide: partial-remainder sign; add/sub: overflow
    logic [2:0] r_cnt;

    logic [8:0] w_add_a;
    logic [8:0] w_add_b;
    logic       w_add_sub;
    logic [8:0] w_sum;
    logic       w_cnt7;
    logic       w_first;
    logic       w_div_ovf;

    assign w_cnt7    = (r_cnt == 3'd7);
    assign w_first   = (r_cnt == 3'd0);
    // Quotient would not fit in 8 bits (also catches divide by zero)
    assign w_div_ovf = (r_a >= r_m);

    // Shared 9-bit adder/subtractor: subtract is a + ~b + 1
    assign w_sum = w_add_a + (w_add_b ^ {9{w_add_sub}}) + {8'd0, w_add_sub};

    // Select adder operands for the active state
    always_comb begin
        w_add_a   = 9'd0;
        w_add_b   = 9'd0;
        w_add_sub = 1'b0;
        case (r_state)
            c_ST_ADDSUB: begin
                w_add_a   = {r_a[7], r_a};
                w_add_b   = {r_m[7], r_m};
                w_add_sub = (r_op == c_OP_SUB);
            end
            c_ST_MUL: begin
                // Sign-extended to 9 bits so the sum never overflows
                w_add_a = {r_a[7], r_a};
                case ({r_q[0], r_q1})
                    2'b01:   w_add_b = {r_m[7], r_m};
                    2'b10: begin
                        w_add_b   = {r_m[7], r_m};
                        w_add_sub = 1'b1;
                    end
                    default: w_add_b = 9'd0;
                endcase
            end
            c_ST_DIV: begin
                // Partial remainder {sign,A,Q} shifted left by one
                w_add_a   = {r_a, r_q[7]};
                w_add_b   = {1'b0, r_m};
                w_add_sub = ~r_sign;
            end
            c_ST_DIVCOR: begin
                w_add_a = {1'b0, r_a};
                w_add_b = {1'b0, r_m};
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_next = c_ST_WAIT;
            c_ST_WAIT:   w_next = c_ST_LDM;
            c_ST_LDM: begin
                case (r_op)
                    c_OP_MUL: w_next = c_ST_MUL;
                    c_OP_DIV: w_next = c_ST_DIV;
                    default:  w_next = c_ST_ADDSUB;
                endcase
            end
            c_ST_ADDSUB: w_next = c_ST_ASOUT;
            c_ST_ASOUT:  w_next = c_ST_IDLE;
            c_ST_MUL:    if (w_cnt7) w_next = c_ST_MULOUT;
            c_ST_MULOUT: w_next = c_ST_IDLE;
            c_ST_DIV: begin
                if (w_first && w_div_ovf) w_next = c_ST_IDLE;
                else if (w_cnt7)          w_next = c_ST_DIVCOR;
            end
            c_ST_DIVCOR: w_next = c_ST_DIVOUT;
            c_ST_DIVOUT: w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // Datapath registers and registered result/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 2'd0;
            r_a     <= 8'd0;
            r_q     <= 8'd0;
            r_m     <= 8'd0;
            r_q1    <= 1'b0;
            r_sign  <= 1'b0;
            r_cnt   <= 3'd0;
            outbus  <= 16'h0000;
            finish  <= 1'b0;
            of_flag <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op    <= sel;
                        r_sign  <= 1'b0;
                        outbus  <= 16'h0000;
                        finish  <= 1'b0;
                        of_flag <= 1'b0;
                        case (sel)
                            c_OP_MUL: begin
                                r_q  <= inbus[7:0];
                                r_a  <= 8'd0;
                                r_q1 <= 1'b0;
                            end
                            c_OP_DIV: begin
                                r_a <= inbus[15:8];
                                r_q <= inbus[7:0];
                            end
                            default: r_a <= inbus[7:0];
                        endcase
                    end
                end
                c_ST_LDM: begin
                    r_m   <= inbus[7:0];
                    r_cnt <= 3'd0;
                end
                c_ST_ADDSUB: begin
                    r_a    <= w_sum[7:0];
                    // Sign-extended operands: overflow when bits 8 and 7 differ
                    r_sign <= w_sum[8] ^ w_sum[7];
                end
                c_ST_ASOUT: begin
                    outbus  <= {8'h00, r_a};
                    of_flag <= r_sign;
                    finish  <= 1'b1;
                end
                c_ST_MUL: begin
                    // Arithmetic shift right of {sum,Q,Q-1}; A[7] comes from the 9-bit sign
                    r_a   <= w_sum[8:1];
                    r_q   <= {w_sum[0], r_q[7:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 3'd1;
                end
                c_ST_MULOUT: begin
                    outbus  <= {r_a, r_q};
                    of_flag <= 1'b0;
                    finish  <= 1'b1;
                end
                c_ST_DIV: begin
                    if (w_first && w_div_ovf) begin
                        outbus  <= 16'hFFFF;
                        of_flag <= 1'b1;
                        finish  <= 1'b1;
                    end else begin
                        r_sign <= w_sum[8];
                        r_a    <= w_sum[7:0];
                        r_q    <= {r_q[6:0], ~w_sum[8]};
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                c_ST_DIVCOR: begin
                    // A negative final remainder is restored by adding M back
                    if (r_sign) r_a <= w_sum[7:0];
                end
                c_ST_DIVOUT: begin
                    outbus  <= {r_a, r_q};
                    of_flag <= 1'b0;
                    finish  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu8
//  Description : Self-checking bench for seq_alu8. Directed vector table,
//                hand-written control sequences and randomized operations
//                checked against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  sel;
    logic [15:0] inbus;
    logic [15:0] outbus;
    logic        finish;
    logic        of_flag;

    int n_vec;
    int n_err;

    seq_alu8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sel     (sel),
        .inbus   (inbus),
        .outbus  (outbus),
        .finish  (finish),
        .of_flag (of_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  s;
        logic [15:0] in1;
        logic [7:0]  in2;
        logic [15:0] eout;
        logic        eof;
        int          elat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning
    function automatic void model(input logic [1:0] s, input logic [15:0] a1, input logic [7:0] b,
                                  output logic [15:0] o, output logic f, output int l);
        int x, y, r, q;
        x = int'($signed(a1[7:0]));
        y = int'($signed(b));
        o = 16'h0000;
        f = 1'b0;
        l = 4;
        case (s)
            2'b00, 2'b01: begin
                r = (s == 2'b00) ? x + y : x - y;
                o = {8'h00, r[7:0]};
                f = (r > 127) || (r < -128);
                l = 4;
            end
            2'b10: begin
                r = x * y;
                o = r[15:0];
                l = 11;
            end
            default: begin
                if (a1[15:8] >= b) begin
                    o = 16'hFFFF;
                    f = 1'b1;
                    l = 3;
                end else begin
                    x = int'(a1);
                    y = int'(b);
                    q = x / y;
                    r = x % y;
                    o = {r[7:0], q[7:0]};
                    l = 12;
                end
            end
        endcase
    endfunction

    // Run one operation; noisy=1 toggles start randomly while busy
    task automatic do_op(input string nm, input logic [1:0] s, input logic [15:0] in1,
                         input logic [7:0] in2, input bit noisy,
                         output logic [15:0] res, output logic rof, output int lat);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        inbus = in1;
        @(posedge clk);
        #1;
        chk({nm, " clear@S"}, {15'd0, finish, of_flag, outbus}, 32'd0);
        start = 1'b0;
        sel   = 2'($urandom);
        inbus = 16'($urandom);
        lat   = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = e;
                break;
            end
            if (e == 1) inbus = in2 | 16'($urandom) << 8;
            else        inbus = 16'($urandom);
            if (noisy) begin
                start = 1'($urandom);
                sel   = 2'($urandom);
            end
        end
        start = 1'b0;
        res = outbus;
        rof = of_flag;
    endtask

    initial begin
        logic [15:0] res, eo;
        logic        rof, ef, seen;
        int          lat, el;
        logic [1:0]  s;
        logic [15:0] a1;
        logic [7:0]  b;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 2'b00;
        inbus = 16'h0000;

        tbl[0]  = '{2'b00, 16'hA514, 8'd75,  16'h005F, 1'b0, 4};
        tbl[1]  = '{2'b00, 16'h007F, 8'd126, 16'h00FD, 1'b1, 4};
        tbl[2]  = '{2'b01, 16'h00B2, 8'd34,  16'h0090, 1'b0, 4};
        tbl[3]  = '{2'b01, 16'h0080, 8'd1,   16'h007F, 1'b1, 4};
        tbl[4]  = '{2'b10, 16'h0028, 8'd12,  16'h01E0, 1'b0, 11};
        tbl[5]  = '{2'b10, 16'h00E7, 8'hD6,  16'h041A, 1'b0, 11};
        tbl[6]  = '{2'b11, 16'h2D16, 8'd135, 16'h4355, 1'b0, 12};
        tbl[7]  = '{2'b11, 16'h9000, 8'h10,  16'hFFFF, 1'b1, 3};
        tbl[8]  = '{2'b11, 16'h0005, 8'h00,  16'hFFFF, 1'b1, 3};
        tbl[9]  = '{2'b11, 16'h86FF, 8'h87,  16'h86FF, 1'b0, 12};
        tbl[10] = '{2'b10, 16'h0080, 8'h80,  16'h4000, 1'b0, 11};
        tbl[11] = '{2'b10, 16'h0080, 8'h7F,  16'hC080, 1'b0, 11};
        tbl[12] = '{2'b01, 16'h007F, 8'hFF,  16'h0080, 1'b1, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {15'd0, finish, of_flag, outbus}, 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].in1, tbl[i].in2, 1'b0, res, rof, lat);
            chk($sformatf("vec%0d outbus", i), {16'd0, res}, {16'd0, tbl[i].eout});
            chk($sformatf("vec%0d of_flag", i), {31'd0, rof}, {31'd0, tbl[i].eof});
            chk($sformatf("vec%0d latency", i), lat, tbl[i].elat);
        end

        // Result holds after completion
        repeat (4) @(posedge clk);
        #1;
        chk("hold", {15'd0, finish, of_flag, outbus}, {15'd0, 1'b1, 1'b1, 16'h0080});

        // start/sel toggled while busy must be ignored
        do_op("busy mul", 2'b10, 16'h0028, 8'd12, 1'b1, res, rof, lat);
        chk("busy mul outbus", {16'd0, res}, {16'd0, 16'h01E0});
        chk("busy mul latency", lat, 11);
        do_op("busy div", 2'b11, 16'h2D16, 8'd135, 1'b1, res, rof, lat);
        chk("busy div outbus", {16'd0, res}, {16'd0, 16'h4355});
        chk("busy div latency", lat, 12);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        sel   = 2'b10;
        inbus = 16'h0028;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        inbus = 16'h000C;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst mid-mul outputs", {15'd0, finish, of_flag, outbus}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            seen = seen | finish;
        end
        chk("rst mid-mul idle", {31'd0, seen}, 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            s  = 2'($urandom);
            a1 = 16'($urandom);
            b  = 8'($urandom);
            if (s == 2'b11 && ($urandom % 4) != 0 && a1[15:8] != 8'hFF)
                b = 8'($urandom_range(255, int'(a1[15:8]) + 1));
            model(s, a1, b, eo, ef, el);
            do_op($sformatf("rnd%0d", i), s, a1, b, 1'b0, res, rof, lat);
            chk($sformatf("rnd%0d op%0d %h/%h outbus", i, s, a1, b), {16'd0, res}, {16'd0, eo});
            chk($sformatf("rnd%0d of_flag", i), {31'd0, rof}, {31'd0, ef});
            chk($sformatf("rnd%0d latency", i), lat, el);
        end

        // Reset clears a held result
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset after result", {15'd0, finish, of_flag, outbus}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
